pll_reconfig_seq: RTL and testbench

//   Parametrised run-time sequencer for the GW5A PLL primitive, driving its dynamic MDSEL/ODSELx/ENCLKx/RESET pins.

---
 rtl/pll_reconfig_pkg.sv | 38 +++
 rtl/pll_reconfig_seq_lock_qualifier.sv | 57 +++++
 rtl/pll_reconfig_seq.sv | 216 +++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_pkg
// Brief    : Shared constants, state encoding and counter sizing for the
//            GW5A PLL run-time reconfiguration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pll_reconfig_pkg;

  // Width of the raw MDSEL/ODSEL select codes on the PLL primitive
  localparam int SEL_W = 7;

  // Channel field width; the all-ones code addresses the feedback divider
  localparam int CH_W = 3;
  localparam logic [CH_W-1:0] CH_MDSEL = 3'd7;

  // Sequencer state encoding
  localparam int ST_W = 3;
  localparam logic [2:0] ST_PRST      = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_UNGATE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_GATE      = 3'd4;
  localparam logic [2:0] ST_APPLY     = 3'd5;
  localparam logic [2:0] ST_HALT      = 3'd6;

  // Counter width large enough to hold the largest of the cycle limits
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reconfig_seq_lock_qualifier.sv
`default_nettype none
// ============================================================================
// Module   : lock_qualifier
// Brief    : Synchronises the asynchronous PLL LOCK pin and runs the lock
//            stability and lock timeout counters while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module lock_qualifier
  import pll_reconfig_pkg::*;
#(
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int CNT_W        = cnt_width(1, 1, LOCK_STABLE, LOCK_TIMEOUT)
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic en,
  output logic lock_sync,
  output logic stable_done,
  output logic timeout
);

  localparam logic [CNT_W-1:0] c_stable_max  = CNT_W'(LOCK_STABLE);
  localparam logic [CNT_W-1:0] c_timeout_max = CNT_W'(LOCK_TIMEOUT);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_stable_cnt;
  logic [CNT_W-1:0] r_timeout_cnt;

  // Two-flop synchroniser for the free-running LOCK pin
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], pll_lock};
  end

  assign lock_sync = r_sync[1];

  // Consecutive lock-high cycles; any low cycle restarts the qualification
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)                      r_stable_cnt <= '0;
    else if (!en || !lock_sync)      r_stable_cnt <= '0;
    else if (r_stable_cnt != c_stable_max) r_stable_cnt <= r_stable_cnt + 1'b1;
  end

  // Total cycles spent waiting for lock, saturating at the limit
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n)                        r_timeout_cnt <= '0;
    else if (!en)                      r_timeout_cnt <= '0;
    else if (r_timeout_cnt != c_timeout_max) r_timeout_cnt <= r_timeout_cnt + 1'b1;
  end

  assign stable_done = (r_stable_cnt == c_stable_max);
  assign timeout     = (r_timeout_cnt == c_timeout_max);

endmodule
`default_nettype wire

// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_seq
// Brief    : Run-time sequencer for the GW5A PLL: power-up reset and lock
//            qualification, glitch-free output divider changes and lock-loss
//            supervision.
// Config   : PLL_LOSS_RECOVERY_EN - when defined, a lock loss in RUN restarts
//            the PLL automatically; otherwise the sequencer halts until reset.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int               NCH          = 3,
  parameter int               RST_CYC      = 64,
  parameter int               GATE_CYC     = 8,
  parameter int               LOCK_STABLE  = 1024,
  parameter int               LOCK_TIMEOUT = 65535,
  parameter logic [SEL_W-1:0] ODSEL_INIT   = 7'd0,
  parameter logic [SEL_W-1:0] MDSEL_INIT   = 7'd0
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CH_W-1:0]        req_ch,
  input  logic [SEL_W-1:0]       req_sel,
  input  logic                   pll_lock,
  output logic                   pll_reset,
  output logic [SEL_W-1:0]       pll_mdsel,
  output logic [SEL_W*NCH-1:0]   pll_odsel,
  output logic [NCH-1:0]         pll_enclk,
  output logic                   locked,
  output logic                   err_timeout,
  output logic                   lock_lost
);

  localparam int CNT_W = cnt_width(RST_CYC, GATE_CYC, LOCK_STABLE, LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] c_rst_last  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] c_gate_last = CNT_W'(GATE_CYC - 1);
  localparam logic [NCH-1:0]   c_all_on    = '1;

  logic [ST_W-1:0]      r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_pll_reset;
  logic [SEL_W-1:0]     r_mdsel;
  logic [SEL_W*NCH-1:0] r_odsel;
  logic [NCH-1:0]       r_enclk;
  logic                 r_locked;
  logic                 r_err;
  logic                 r_lost;
  logic [CH_W-1:0]      r_ch;
  logic [SEL_W-1:0]     r_sel;

  logic                 w_lock_sync;
  logic                 w_stable_done;
  logic                 w_timeout;
  logic [NCH-1:0]       w_req_mask;
  logic [NCH-1:0]       w_ch_mask;
  logic                 w_req_is_md;
  logic                 w_req_ok;

  lock_qualifier #(
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_lock_qualifier (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .en          (r_state == ST_WAIT_LOCK),
    .lock_sync   (w_lock_sync),
    .stable_done (w_stable_done),
    .timeout     (w_timeout)
  );

  // One-hot channel decode for the incoming request and the captured request
  always_comb begin
    w_req_mask = '0;
    w_ch_mask  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_req_mask[i] = (req_ch == CH_W'(i));
      w_ch_mask[i]  = (r_ch == CH_W'(i));
    end
  end

  // Channels beyond NCH (other than the feedback code) are accepted but dropped
  assign w_req_is_md = (req_ch == CH_MDSEL);
  assign w_req_ok    = (|w_req_mask) || w_req_is_md;

  // Requests are only taken while running with a currently valid lock
  assign req_ready = (r_state == ST_RUN) && w_lock_sync;

  // Sequencer: state, gate/reset timer and all registered PLL-facing outputs
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_PRST;
      r_cnt       <= '0;
      r_pll_reset <= 1'b1;
      r_mdsel     <= MDSEL_INIT;
      r_odsel     <= {NCH{ODSEL_INIT}};
      r_enclk     <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_lost      <= 1'b0;
      r_ch        <= '0;
      r_sel       <= '0;
    end else begin
      r_lost <= 1'b0;
      case (r_state)
        ST_PRST: begin
          if (r_cnt == c_rst_last) begin
            r_cnt       <= '0;
            r_pll_reset <= 1'b0;
            r_state     <= ST_WAIT_LOCK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_stable_done) begin
            r_cnt   <= '0;
            r_state <= ST_UNGATE;
          end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_locked    <= 1'b0;
            r_enclk     <= '0;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_state     <= ST_PRST;
          end
        end
        ST_UNGATE: begin
          if (r_cnt == c_gate_last) begin
            r_cnt    <= '0;
            r_enclk  <= c_all_on;
            r_locked <= 1'b1;
            r_state  <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_lock_sync) begin
            r_lost   <= 1'b1;
            r_locked <= 1'b0;
            r_enclk  <= '0;
`ifdef PLL_LOSS_RECOVERY_EN
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_state     <= ST_PRST;
`else
            r_state <= ST_HALT;
`endif
          end else if (req_valid) begin
            r_err <= 1'b0;
            if (w_req_ok) begin
              r_ch    <= req_ch;
              r_sel   <= req_sel;
              r_cnt   <= '0;
              r_state <= ST_GATE;
              if (w_req_is_md) begin
                r_enclk  <= '0;
                r_locked <= 1'b0;
              end else begin
                r_enclk <= r_enclk & ~w_req_mask;
              end
            end
          end
        end
        ST_GATE: begin
          if (r_cnt == c_gate_last) begin
            r_cnt   <= '0;
            r_state <= ST_APPLY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_APPLY: begin
          if (r_ch == CH_MDSEL) begin
            // Feedback divider change needs a full PLL reset and relock
            r_mdsel     <= r_sel;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_state     <= ST_PRST;
          end else begin
            for (int i = 0; i < NCH; i++) begin
              if (w_ch_mask[i]) r_odsel[i*SEL_W +: SEL_W] <= r_sel;
            end
            r_state <= ST_WAIT_LOCK;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_enclk     <= '0;
          r_locked    <= 1'b0;
          r_cnt       <= '0;
          r_pll_reset <= 1'b1;
          r_state     <= ST_PRST;
        end
      endcase
    end
  end

  assign pll_reset   = r_pll_reset;
  assign pll_mdsel   = r_mdsel;
  assign pll_odsel   = r_odsel;
  assign pll_enclk   = r_enclk;
  assign locked      = r_locked;
  assign err_timeout = r_err;
  assign lock_lost   = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reconfig_seq
// Brief    : Self-checking bench for pll_reconfig_seq with a behavioural PLL
//            lock model, a request table and an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_seq;

  localparam int NCH          = 3;
  localparam int RST_CYC      = 8;
  localparam int GATE_CYC     = 4;
  localparam int LOCK_STABLE  = 16;
  localparam int LOCK_TIMEOUT = 300;
  localparam int LOCK_DLY     = 200;
  localparam logic [6:0] ODSEL_INIT = 7'd5;
  localparam logic [6:0] MDSEL_INIT = 7'd9;
  localparam logic [20:0] ODSEL_RST = {7'd5, 7'd5, 7'd5};

  // Lock latency from LOCK rising: 2 sync flops + 1 count register,
  // LOCK_STABLE qualification, GATE_CYC before the clocks are enabled
  localparam int PWRUP_LAT = LOCK_DLY + LOCK_STABLE + GATE_CYC + 3;
  // ODSEL change: gate, apply, requalify (LOCK_STABLE+1), ungate
  localparam int ODSEL_LOW = 2 * GATE_CYC + LOCK_STABLE + 2;
  // MDSEL change: gate, apply, PLL reset, lock delay, requalify, ungate
  localparam int MDSEL_LOW = 2 * GATE_CYC + RST_CYC + LOCK_DLY + LOCK_STABLE + 3;

  logic clk;
  logic rst_n;
  logic req_valid;
  logic req_ready;
  logic [2:0] req_ch;
  logic [6:0] req_sel;
  logic pll_lock;
  logic pll_reset;
  logic [6:0] pll_mdsel;
  logic [7*NCH-1:0] pll_odsel;
  logic [NCH-1:0] pll_enclk;
  logic locked;
  logic err_timeout;
  logic lock_lost;

  logic lock_hold;
  logic lock_drop;
  int   lock_ctr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  ch;
    logic [6:0]  sel;
    logic [20:0] odsel;
    logic [6:0]  mdsel;
    int          reset_hi;
    int          gate_low;
    logic [2:0]  en_and;
  } vec_t;

  vec_t tbl[5];
  vec_t sb_q[$];

  pll_reconfig_seq #(
    .NCH          (NCH),
    .RST_CYC      (RST_CYC),
    .GATE_CYC     (GATE_CYC),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .ODSEL_INIT   (ODSEL_INIT),
    .MDSEL_INIT   (MDSEL_INIT)
  ) dut (
    .clkin       (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ch      (req_ch),
    .req_sel     (req_sel),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .pll_mdsel   (pll_mdsel),
    .pll_odsel   (pll_odsel),
    .pll_enclk   (pll_enclk),
    .locked      (locked),
    .err_timeout (err_timeout),
    .lock_lost   (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PLL model: LOCK rises LOCK_DLY cycles after RESET falls
  initial begin
    pll_lock = 1'b0;
    lock_ctr = 0;
    forever begin
      @(negedge clk);
      if (pll_reset) lock_ctr = 0;
      else if (lock_ctr < LOCK_DLY) lock_ctr++;
      pll_lock = (lock_ctr == LOCK_DLY) && !lock_hold && !lock_drop;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_run(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = req_ready && locked;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic do_request(input logic [2:0] ch, input logic [6:0] sel,
                            output int reset_hi, output int gate_low,
                            output logic [NCH-1:0] en_and);
    bit done;
    reset_hi = 0;
    gate_low = 0;
    en_and   = '1;
    done     = 1'b0;
    wait_run("ready_before_req", 3000);
    req_ch    = ch;
    req_sel   = sel;
    req_valid = 1'b1;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(negedge clk);
      if (n == 0) req_valid = 1'b0;
      if (pll_reset) reset_hi++;
      if (pll_enclk != '1) gate_low++;
      en_and &= pll_enclk;
      done = req_ready && locked;
    end
    check("seq_completes", 32'(done), 32'd1);
  endtask

  initial begin
    int   rh, gl, k, lost_cnt;
    logic [NCH-1:0] ea;
    vec_t exp_v;
    bit   seen, ok;

    rst_n = 1'b0; req_valid = 1'b0; req_ch = '0; req_sel = '0;
    lock_hold = 1'b0; lock_drop = 1'b0;

    tbl[0] = '{3'd1, 7'd20,  {7'd5, 7'd20, 7'd5},   7'd9,  0,       ODSEL_LOW, 3'b101};
    tbl[1] = '{3'd7, 7'd30,  {7'd5, 7'd20, 7'd5},   7'd30, RST_CYC, MDSEL_LOW, 3'b000};
    tbl[2] = '{3'd5, 7'd99,  {7'd5, 7'd20, 7'd5},   7'd30, 0,       0,         3'b111};
    tbl[3] = '{3'd0, 7'd127, {7'd5, 7'd20, 7'd127}, 7'd30, 0,       ODSEL_LOW, 3'b110};
    tbl[4] = '{3'd2, 7'd0,   {7'd0, 7'd20, 7'd127}, 7'd30, 0,       ODSEL_LOW, 3'b011};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_pll_reset", 32'(pll_reset), 32'd1);
    check("rst_enclk", 32'(pll_enclk), 32'd0);
    check("rst_odsel", 32'(pll_odsel), 32'(ODSEL_RST));
    check("rst_mdsel", 32'(pll_mdsel), 32'(MDSEL_INIT));
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);
    rst_n = 1'b1;

    // Power-up: latency from PLL reset release to qualified lock
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !pll_reset;
    end
    check("pwrup_reset_release", 32'(ok), 32'd1);
    k = 1;
    while (!locked && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("pwrup_lock_latency", 32'(k), 32'(PWRUP_LAT));
    check("pwrup_enclk", 32'(pll_enclk), 32'b111);
    check("pwrup_req_ready", 32'(req_ready), 32'd1);

    // Request table through the expected-result queue
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(tbl[i]);
      do_request(tbl[i].ch, tbl[i].sel, rh, gl, ea);
      exp_v = sb_q.pop_front();
      check($sformatf("vec%0d_reset_hi", i), 32'(rh), 32'(exp_v.reset_hi));
      check($sformatf("vec%0d_gate_low", i), 32'(gl), 32'(exp_v.gate_low));
      check($sformatf("vec%0d_enclk_gated", i), 32'(ea), 32'(exp_v.en_and));
      check($sformatf("vec%0d_odsel", i), 32'(pll_odsel), 32'(exp_v.odsel));
      check($sformatf("vec%0d_mdsel", i), 32'(pll_mdsel), 32'(exp_v.mdsel));
      check($sformatf("vec%0d_enclk_after", i), 32'(pll_enclk), 32'b111);
    end

    // Timeout: PLL refuses to lock after an ODSEL change
    wait_run("ready_before_timeout", 3000);
    req_ch = 3'd2; req_sel = 7'd50; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1 lock_hold = 1'b1;
    k = 1;
    while (!err_timeout && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", 32'(k), 32'(GATE_CYC + LOCK_TIMEOUT + 3));
    check("timeout_enters_prst", 32'(pll_reset), 32'd1);
    check("timeout_odsel", 32'(pll_odsel), 32'({7'd50, 7'd20, 7'd127}));
    lock_hold = 1'b0;
    wait_run("relock_after_timeout", 3000);
    check("timeout_sticky", 32'(err_timeout), 32'd1);
    do_request(3'd4, 7'd1, rh, gl, ea);
    check("timeout_cleared", 32'(err_timeout), 32'd0);

    // Asynchronous reset while gating a channel
    wait_run("ready_before_async_rst", 3000);
    req_ch = 3'd0; req_sel = 7'd77; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("gate_entered", 32'(pll_enclk), 32'b110);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_pll_reset", 32'(pll_reset), 32'd1);
    check("arst_enclk", 32'(pll_enclk), 32'd0);
    check("arst_odsel", 32'(pll_odsel), 32'(ODSEL_RST));
    check("arst_mdsel", 32'(pll_mdsel), 32'(MDSEL_INIT));
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_run("relock_after_arst", 3000);
    check("arst_not_retried", 32'(pll_odsel), 32'(ODSEL_RST));
    check("arst_enclk_after", 32'(pll_enclk), 32'b111);

    // Lock loss while running: one-cycle LOCK drop
    @(negedge clk);
    #1 lock_drop = 1'b1;
    @(negedge clk);
    #1 lock_drop = 1'b0;
    lost_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lock_lost) begin
        lost_cnt++;
        if (!seen) begin
          check("loss_enclk", 32'(pll_enclk), 32'd0);
          check("loss_locked", 32'(locked), 32'd0);
          seen = 1'b1;
        end
      end
    end
    check("loss_pulse_count", 32'(lost_cnt), 32'd1);
`ifdef PLL_LOSS_RECOVERY_EN
    wait_run("loss_relock", 3000);
    check("loss_enclk_restored", 32'(pll_enclk), 32'b111);
`else
    repeat (30) @(negedge clk);
    check("halt_req_ready", 32'(req_ready), 32'd0);
    check("halt_enclk", 32'(pll_enclk), 32'd0);
    check("halt_locked", 32'(locked), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
